// File: rtl/demo_scene_sequencer.sv
// demo_scene_sequencer: frame-locked scene scheduler. Walks a small
// programmable scene table, producing a per-scene control word, a
// brightness fade envelope and a scene-entry pulse.
`ifndef EXT_CONTROL_BITS
`define EXT_CONTROL_BITS 8
`endif

module demo_scene_sequencer #(
  parameter  int NUM_SCENES = 8,
  parameter  int DUR_BITS   = 10,
  parameter  int FADE_BITS  = 4,
  parameter  int CTRL_BITS  = `EXT_CONTROL_BITS,
  localparam int SI_BITS    = $clog2(NUM_SCENES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_frame,
  input  logic                 hold,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cfg_we,
  input  logic [SI_BITS-1:0]   cfg_addr,
  input  logic [DUR_BITS-1:0]  cfg_duration,
  input  logic [CTRL_BITS-1:0] cfg_control,
  input  logic                 cfg_last,
  output logic [CTRL_BITS-1:0] ext_control,
  output logic [SI_BITS-1:0]   scene,
  output logic [FADE_BITS-1:0] fade,
  output logic                 busy,
  output logic                 scene_start
);

  typedef enum logic [1:0] {IDLE, FADE_IN, SHOW, FADE_OUT} state_t;

  typedef struct packed {
    logic [DUR_BITS-1:0]  dur;
    logic [CTRL_BITS-1:0] ctrl;
    logic                 last;
  } entry_t;

  localparam logic [FADE_BITS-1:0] FMAX     = '1;
  localparam logic [FADE_BITS-1:0] FONE     = 1;
  localparam logic [SI_BITS-1:0]   LAST_IDX = SI_BITS'(NUM_SCENES - 1);

  entry_t               tbl [NUM_SCENES];
  entry_t               cur;
  state_t               state, state_n;
  logic [SI_BITS-1:0]   scene_n;
  logic [FADE_BITS-1:0] fade_n;
  logic [DUR_BITS-1:0]  fcnt, fcnt_n, fcnt_inc;
  logic                 stop_flag, stop_flag_n, scene_start_n;
  logic                 step;

  // Current entry is read combinationally, so a same-cycle write is not yet
  // visible here; an edit to the live scene takes effect on the next step.
  assign cur      = tbl[scene];
  assign step     = new_frame && !hold;
  assign fcnt_inc = fcnt + 1'b1;

  // Scene table: cleared on reset, writable in any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SCENES; i++) tbl[i] <= '0;
    end else if (cfg_we && (32'(cfg_addr) < NUM_SCENES)) begin
      tbl[cfg_addr] <= '{dur: cfg_duration, ctrl: cfg_control, last: cfg_last};
    end
  end

  // Next-state logic; commands take priority and swallow a same-cycle step.
  always_comb begin
    state_n       = state;
    scene_n       = scene;
    fade_n        = fade;
    fcnt_n        = fcnt;
    stop_flag_n   = stop_flag;
    scene_start_n = 1'b0;
    if (state == IDLE) begin
      if (start && !stop) begin
        state_n       = FADE_IN;
        scene_n       = '0;
        fade_n        = '0;
        fcnt_n        = '0;
        stop_flag_n   = 1'b0;
        scene_start_n = 1'b1;
      end
    end else if (stop) begin
      // Fade out gracefully if anything is visible, otherwise drop at once.
      if (fade != '0) begin
        state_n     = FADE_OUT;
        stop_flag_n = 1'b1;
      end else begin
        state_n     = IDLE;
        stop_flag_n = 1'b0;
      end
    end else if (step) begin
      case (state)
        FADE_IN: begin
          if (fade >= FMAX - FONE) begin
            fade_n = FMAX;
            if (cur.dur != '0) begin
              state_n = SHOW;
              fcnt_n  = '0;
            end else begin
              state_n = FADE_OUT;
            end
          end else begin
            fade_n = fade + FONE;
          end
        end
        SHOW: begin
          fcnt_n = fcnt_inc;
          if (fcnt_inc == cur.dur) state_n = FADE_OUT;
        end
        FADE_OUT: begin
          if (fade <= FONE) begin
            fade_n = '0;
            if (stop_flag) begin
              state_n     = IDLE;
              stop_flag_n = 1'b0;
            end else begin
              state_n       = FADE_IN;
              scene_n       = (cur.last || scene == LAST_IDX) ? '0 : scene + 1'b1;
              scene_start_n = 1'b1;
            end
          end else begin
            fade_n = fade - FONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      scene       <= '0;
      fade        <= '0;
      fcnt        <= '0;
      stop_flag   <= 1'b0;
      busy        <= 1'b0;
      scene_start <= 1'b0;
      ext_control <= '0;
    end else begin
      state       <= state_n;
      scene       <= scene_n;
      fade        <= fade_n;
      fcnt        <= fcnt_n;
      stop_flag   <= stop_flag_n;
      busy        <= (state_n != IDLE);
      scene_start <= scene_start_n;
      // Follows the registered scene, hence one cycle behind a scene change.
      ext_control <= (state == IDLE) ? '0 : cur.ctrl;
    end
  end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Directed bench for demo_scene_sequencer with FADE_BITS=2 (FMAX=3).
module tb_demo_scene_sequencer;
  localparam int NS = 4, DB = 10, FB = 2, CB = 8, SB = 2;

  logic          clk = 1'b0;
  logic          reset, new_frame, hold, start, stop, cfg_we, cfg_last;
  logic [SB-1:0] cfg_addr;
  logic [DB-1:0] cfg_duration;
  logic [CB-1:0] cfg_control;
  logic [CB-1:0] ext_control;
  logic [SB-1:0] scene;
  logic [FB-1:0] fade;
  logic          busy, scene_start;

  int total = 0;
  int bad   = 0;

  demo_scene_sequencer #(.NUM_SCENES(NS), .DUR_BITS(DB), .FADE_BITS(FB), .CTRL_BITS(CB)) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .hold(hold), .start(start), .stop(stop),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_duration(cfg_duration), .cfg_control(cfg_control),
    .cfg_last(cfg_last), .ext_control(ext_control), .scene(scene), .fade(fade), .busy(busy),
    .scene_start(scene_start));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic step();
    new_frame = 1'b1; cyc(); new_frame = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic wr(input int a, input int d, input int c, input bit l);
    cfg_we = 1'b1; cfg_addr = SB'(a); cfg_duration = DB'(d); cfg_control = CB'(c); cfg_last = l;
    cyc(); cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
    total++; if (fade !== 2'd0) begin bad++; $display("FAIL rst_fade got=%0d exp=0", fade); end
    total++; if (scene !== 2'd0) begin bad++; $display("FAIL rst_scene got=%0d exp=0", scene); end
    total++; if (ext_control !== 8'h00) begin bad++; $display("FAIL rst_ctrl got=%0h exp=0", ext_control); end
    total++; if (scene_start !== 1'b0) begin bad++; $display("FAIL rst_ss got=%0d exp=0", scene_start); end
    reset = 1'b0; cyc();
  endtask

  task automatic test_basic();
    int exp_f [11] = '{1, 2, 3, 3, 3, 3, 3, 3, 2, 1, 0};
    wr(0, 5, 8'hA5, 1'b1);
    do_start();
    total++; if (scene_start !== 1'b1 || busy !== 1'b1 || fade !== 2'd0) begin
      bad++; $display("FAIL basic_start ss=%0d busy=%0d fade=%0d exp=1,1,0", scene_start, busy, fade); end
    cyc();
    total++; if (scene_start !== 1'b0) begin bad++; $display("FAIL basic_ss_width got=%0d exp=0", scene_start); end
    total++; if (ext_control !== 8'hA5) begin bad++; $display("FAIL basic_ctrl got=%0h exp=a5", ext_control); end
    for (int i = 0; i < 11; i++) begin
      step();
      total++; if (fade !== FB'(exp_f[i])) begin
        bad++; $display("FAIL basic_fade step=%0d got=%0d exp=%0d", i + 1, fade, exp_f[i]); end
      total++; if (scene_start !== (i == 10)) begin
        bad++; $display("FAIL basic_ss step=%0d got=%0d exp=%0d", i + 1, scene_start, i == 10); end
      if (i == 4) begin
        do_start();
        total++; if (scene_start !== 1'b0 || fade !== 2'd3) begin
          bad++; $display("FAIL basic_start_busy ss=%0d fade=%0d exp=0,3", scene_start, fade); end
      end
    end
    total++; if (scene !== 2'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_wrap scene=%0d busy=%0d exp=0,1", scene, busy); end
    do_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_stop0 busy=%0d exp=0", busy); end
  endtask

  task automatic test_multi();
    int       exp_cnt [3] = '{7, 6, 8};
    int       exp_nxt [3] = '{1, 2, 0};
    int       exp_ctl [3] = '{8'h11, 8'h22, 8'h33};
    int       fh [20];
    int       n;
    bit       done;
    wr(0, 1, 8'h11, 1'b0);
    wr(1, 0, 8'h22, 1'b0);
    wr(2, 2, 8'h33, 1'b1);
    do_start();
    for (int s = 0; s < 3; s++) begin
      n = 0; done = 1'b0;
      while (!done && n < 20) begin
        step();
        fh[n] = int'(fade);
        n++;
        if (n == 1) begin
          total++; if (ext_control !== CB'(exp_ctl[s])) begin
            bad++; $display("FAIL multi_ctrl scene=%0d got=%0h exp=%0h", s, ext_control, exp_ctl[s]); end
        end
        if (scene_start) done = 1'b1;
      end
      total++; if (n != exp_cnt[s]) begin
        bad++; $display("FAIL multi_len scene=%0d got=%0d exp=%0d", s, n, exp_cnt[s]); end
      total++; if (scene !== SB'(exp_nxt[s])) begin
        bad++; $display("FAIL multi_next scene=%0d got=%0d exp=%0d", s, scene, exp_nxt[s]); end
      if (s == 1) begin
        total++; if (fh[3] != 2) begin
          bad++; $display("FAIL multi_noshow fade4=%0d exp=2", fh[3]); end
      end
    end
    do_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL multi_stop busy=%0d exp=0", busy); end
  endtask

  task automatic test_stop();
    wr(0, 10, 8'h5A, 1'b0);
    do_start();
    for (int i = 0; i < 5; i++) step();
    new_frame = 1'b1; stop = 1'b1; cyc(); new_frame = 1'b0; stop = 1'b0;
    total++; if (fade !== 2'd3 || busy !== 1'b1) begin
      bad++; $display("FAIL stop_cmd fade=%0d busy=%0d exp=3,1", fade, busy); end
    step();
    total++; if (fade !== 2'd2) begin bad++; $display("FAIL stop_f1 got=%0d exp=2", fade); end
    step(); step();
    total++; if (fade !== 2'd0 || busy !== 1'b0 || scene !== 2'd0 || scene_start !== 1'b0) begin
      bad++; $display("FAIL stop_end fade=%0d busy=%0d scene=%0d ss=%0d exp=0,0,0,0", fade, busy, scene, scene_start); end
    cyc();
    total++; if (ext_control !== 8'h00) begin bad++; $display("FAIL stop_ctrl got=%0h exp=0", ext_control); end
  endtask

  task automatic test_hold();
    wr(0, 6, 8'h77, 1'b0);
    do_start();
    for (int i = 0; i < 5; i++) step();
    hold = 1'b1;
    for (int i = 0; i < 20; i++) step();
    total++; if (fade !== 2'd3 || busy !== 1'b1) begin
      bad++; $display("FAIL hold_frozen fade=%0d busy=%0d exp=3,1", fade, busy); end
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (fade !== 2'd3) begin bad++; $display("FAIL hold_resume step=%0d fade=%0d exp=3", i, fade); end
    end
    step();
    total++; if (fade !== 2'd2) begin bad++; $display("FAIL hold_fadeout got=%0d exp=2", fade); end
    do_stop(); step(); step();
    total++; if (busy !== 1'b0 || scene !== 2'd0) begin
      bad++; $display("FAIL hold_stop busy=%0d scene=%0d exp=0,0", busy, scene); end
  endtask

  task automatic test_same_cycle();
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    total++; if (busy !== 1'b0 || scene_start !== 1'b0) begin
      bad++; $display("FAIL same_ss busy=%0d ss=%0d exp=0,0", busy, scene_start); end
    start = 1'b1; new_frame = 1'b1; cyc(); start = 1'b0; new_frame = 1'b0;
    total++; if (fade !== 2'd0 || busy !== 1'b1 || scene_start !== 1'b1) begin
      bad++; $display("FAIL same_step fade=%0d busy=%0d ss=%0d exp=0,1,1", fade, busy, scene_start); end
    do_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL same_stop busy=%0d exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    wr(0, 2, 8'hC3, 1'b0);
    do_start();
    for (int i = 0; i < 6; i++) step();
    total++; if (fade !== 2'd2) begin bad++; $display("FAIL rmid_pre fade=%0d exp=2", fade); end
    reset = 1'b1; cyc(); reset = 1'b0;
    total++; if (busy !== 1'b0 || fade !== 2'd0 || scene !== 2'd0 || ext_control !== 8'h00 || scene_start !== 1'b0) begin
      bad++; $display("FAIL rmid_rst busy=%0d fade=%0d scene=%0d ctrl=%0h ss=%0d exp=all 0",
                      busy, fade, scene, ext_control, scene_start); end
    do_start();
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) begin
        total++; if (ext_control !== 8'h00) begin bad++; $display("FAIL rmid_ctrl got=%0h exp=0", ext_control); end
      end
      if (i == 4) begin
        total++; if (fade !== 2'd2) begin bad++; $display("FAIL rmid_dur0 fade=%0d exp=2", fade); end
      end
      if (i == 6 || i == 12) begin
        total++; if (scene_start !== 1'b1 || scene !== SB'(i / 6)) begin
          bad++; $display("FAIL rmid_scene step=%0d ss=%0d scene=%0d exp=1,%0d", i, scene_start, scene, i / 6); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; new_frame = 1'b0; hold = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_duration = '0; cfg_control = '0; cfg_last = 1'b0;
    test_reset();
    test_basic();
    test_multi();
    test_stop();
    test_hold();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
